// File: rtl/ifid_buf.sv
// Two-entry IF/ID skid buffer; decoded fields are slices of the registered head.
// Ports: clk, reset, in_* (fetch side), flush, out_* (decode side). Macro: IFID_FLUSH_EN.
module ifid_buf #(
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc4,
  output logic [5:0]  out_op,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16,
  output logic [25:0] out_jaddr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  localparam ent_t NOP_ENT = '{instr: NOP_WORD, pc4: 32'h0};

  state_t state;
  ent_t   head;
  ent_t   tail;
  ent_t   new_ent;
  logic   push;
  logic   pop;
  logic   kill;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign new_ent   = '{instr: in_instr, pc4: in_pc4};

`ifdef IFID_FLUSH_EN
  assign kill = flush;
`else
  logic unused_flush;
  assign kill         = 1'b0;
  assign unused_flush = flush;
`endif

  // Head always holds NOP_ENT while empty, so outputs need no muxing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      head  <= NOP_ENT;
      tail  <= NOP_ENT;
    end else if (kill) begin
      state <= EMPTY;
      head  <= NOP_ENT;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_ent;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: head <= new_ent;
            2'b10: begin
              tail  <= new_ent;
              state <= FULL;
            end
            2'b01: begin
              head  <= NOP_ENT;
              state <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          head  <= NOP_ENT;
        end
      endcase
    end
  end

  assign out_pc4   = head.pc4;
  assign out_op    = head.instr[31:26];
  assign out_rs    = head.instr[25:21];
  assign out_rt    = head.instr[20:16];
  assign out_rd    = head.instr[15:11];
  assign out_shamt = head.instr[10:6];
  assign out_funct = head.instr[5:0];
  assign out_imm16 = head.instr[15:0];
  assign out_jaddr = head.instr[25:0];

endmodule

// File: tb/tb_ifid_buf.sv
// Scoreboard bench for ifid_buf: directed vectors plus a random handshake run.
// A negedge monitor models occupancy and checks every popped head.
module tb_ifid_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [5:0]  out_op;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [25:0] out_jaddr;

  ifid_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc4   (out_pc4),
    .out_op    (out_op),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_rd    (out_rd),
    .out_shamt (out_shamt),
    .out_funct (out_funct),
    .out_imm16 (out_imm16),
    .out_jaddr (out_jaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t sb[$];
  int   cnt   = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Occupancy model + scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    ent_t e;
    logic acc;
    logic pp;
    if (reset) begin
      sb.delete();
      cnt = 0;
    end else begin
      chk("mon_in_ready", {31'b0, in_ready}, {31'b0, cnt < 2});
      chk("mon_out_valid", {31'b0, out_valid}, {31'b0, cnt > 0});
      acc = in_valid && (cnt < 2);
      pp  = out_ready && (cnt > 0);
`ifdef IFID_FLUSH_EN
      if (flush) begin
        sb.delete();
        cnt = 0;
        acc = 1'b0;
        pp  = 1'b0;
      end
`endif
      if (pp) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_underflow actual=pop required=none");
        end else begin
          e = sb.pop_front();
          chk("mon_pc4", out_pc4, e.pc4);
          chk("mon_fields",
              {out_op, out_rs, out_rt, out_rd, out_shamt, out_funct},
              e.instr);
          chk("mon_imm16", {16'b0, out_imm16}, {16'b0, e.instr[15:0]});
          chk("mon_jaddr", {6'b0, out_jaddr}, {6'b0, e.instr[25:0]});
        end
        cnt--;
      end
      if (acc) begin
        sb.push_back('{instr: in_instr, pc4: in_pc4});
        cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] p, input logic r);
    in_valid  = v;
    in_instr  = i;
    in_pc4    = p;
    out_ready = r;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_pc4", out_pc4, 32'd0);
    chk("rst_fields",
        {out_op, out_rs, out_rt, out_rd, out_shamt, out_funct}, 32'd0);
    reset = 1'b0;

    // Single push with immediate consume
    drive(1'b1, 32'h2008FFD5, 32'h00400004, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    chk("p1_valid", {31'b0, out_valid}, 32'd1);
    chk("p1_op", {26'b0, out_op}, 32'h08);
    chk("p1_rt", {27'b0, out_rt}, 32'd8);
    chk("p1_imm16", {16'b0, out_imm16}, 32'hFFD5);
    chk("p1_pc4", out_pc4, 32'h00400004);
    step();
    chk("p1_empty", {31'b0, out_valid}, 32'd0);
    chk("p1_nop_imm", {16'b0, out_imm16}, 32'h0);

    // Fill to FULL with decode stalled
    drive(1'b1, 32'h34080EC6, 32'h00400008, 1'b0);
    step();
    drive(1'b1, 32'h00851020, 32'h0040000C, 1'b0);
    step();
    chk("f_in_ready", {31'b0, in_ready}, 32'd0);
    chk("f_imm16", {16'b0, out_imm16}, 32'h0EC6);
    drive(1'b1, 32'h3C011001, 32'h00400010, 1'b0);
    step();
    chk("f_hold_imm", {16'b0, out_imm16}, 32'h0EC6);
    chk("f_hold_pc4", out_pc4, 32'h00400008);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("f_rd", {27'b0, out_rd}, 32'd2);
    chk("f_funct", {26'b0, out_funct}, 32'h20);

    // ONE with simultaneous push and pop
    drive(1'b1, 32'h08100000, 32'h00400014, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pp_valid", {31'b0, out_valid}, 32'd1);
    chk("pp_in_ready", {31'b0, in_ready}, 32'd1);
    chk("pp_op", {26'b0, out_op}, 32'h02);
    chk("pp_jaddr", {6'b0, out_jaddr}, 32'h0100000);

    // Async reset while FULL
    drive(1'b1, 32'h8C880004, 32'h00400018, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("r_full", {31'b0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("r_out_valid", {31'b0, out_valid}, 32'd0);
    chk("r_in_ready", {31'b0, in_ready}, 32'd1);
    chk("r_imm16", {16'b0, out_imm16}, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b1, 32'hAC890008, 32'h0040001C, 1'b0);
    step();
    chk("r_new_head", out_pc4, 32'h0040001C);

    // Flush while FULL with a push offered
    drive(1'b1, 32'h01095020, 32'h00400020, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h11000003, 32'h00400024, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef IFID_FLUSH_EN
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
`else
    chk("fl_valid", {31'b0, out_valid}, 32'd1);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    chk("fl_head", out_pc4, 32'h0040001C);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (3) step();

    // Random handshake stream
    for (int k = 0; k < 1000; k++) begin
      drive(1'($urandom), $urandom, 32'h00500000 + 32'(k * 4),
            1'($urandom));
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (4) step();
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifid_buf.md
IFID_BUF -- requirements
Module: ifid_buf

Interface
REQ-001 SHALL have parameter NOP_WORD, default 32'h00000000, the instruction word presented on decoded outputs while empty.
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream fetch offers an instruction.
REQ-005 SHALL have port in_ready  output  1  buffer accepts an instruction this cycle.
REQ-006 SHALL have port in_instr  input  32  fetched instruction word.
REQ-007 SHALL have port in_pc4  input  32  PC+4 of that instruction.
REQ-008 SHALL have port flush  input  1  discard all buffered instructions (active only with IFID_FLUSH_EN).
REQ-009 SHALL have port out_valid  output  1  head entry valid toward decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes the head entry.
REQ-011 SHALL have port out_pc4  output  32  head PC+4.
REQ-012 SHALL have ports out_op[5:0]=instr[31:26], out_rs[4:0]=[25:21], out_rt[4:0]=[20:16], out_rd[4:0]=[15:11], out_shamt[4:0]=[10:6], out_funct[5:0]=[5:0], all outputs.
REQ-013 SHALL have port out_imm16  output  16  instr[15:0], wired directly to the 16-to-32 sign-extender input.
REQ-014 SHALL have port out_jaddr  output  26  instr[25:0] jump target field.

Function
REQ-015 SHALL store up to 2 {instr, pc4} entries in FIFO order; states EMPTY (0), ONE (1), FULL (2).
REQ-016 SHALL assert in_ready exactly when state is not FULL, combinationally from state only (never from out_ready).
REQ-017 SHALL push on a rising edge when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-018 SHALL assert out_valid exactly when state is not EMPTY; all decoded outputs are registered-entry slices of the head, no combinational path from in_instr.
REQ-019 SHALL drive decoded outputs from NOP_WORD and out_pc4=0 while EMPTY.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new entry as head; FULL+pop->ONE with second entry promoted; no event->hold.
REQ-021 SHALL have latency 1 cycle: an instruction pushed at edge N is visible on outputs after edge N when it becomes head.
REQ-022 SHALL hold head entry and all outputs stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_valid when in_ready is low; no entry dropped or duplicated.
REQ-024 SHALL perform field extraction purely by bit slicing, no sign or zero extension inside this block.

Reset
REQ-025 SHALL, on reset assertion, asynchronously force state EMPTY, out_valid=0, in_ready=1, decoded outputs per NOP_WORD, out_pc4=0.
REQ-026 SHALL discard any in-flight entries when reset asserts mid-operation; first push after deassertion becomes head.

Configuration
REQ-027 With IFID_FLUSH_EN defined: flush high at an edge SHALL force EMPTY, overriding simultaneous push and pop (incoming instruction dropped).
REQ-028 Without IFID_FLUSH_EN: flush SHALL be ignored; port remains present.

Verification
REQ-029 Push 32'h2008FFD5, pc4=32'h00400004, out_ready=1 -> next cycle out_valid=1, out_op=6'h08, out_rt=5'd8, out_imm16=16'hFFD5 (sign-extends to -43 downstream).
REQ-030 Push 32'h34080EC6 then 32'h00851020 with out_ready=0 -> FULL, in_ready=0, head imm16=16'h0EC6 (3782); third push ignored; release out_ready -> second entry shows out_rd=5'd2, out_funct=6'h20.
REQ-031 In ONE, simultaneous push 32'h08100000 and pop -> remains ONE, out_op=6'h02, out_jaddr=26'h0100000.
REQ-032 Assert reset while FULL -> immediately out_valid=0, in_ready=1, out_imm16=16'h0000.
REQ-033 With IFID_FLUSH_EN, flush while FULL and in_valid=1 -> EMPTY next cycle, out_valid=0; without macro same stimulus -> FULL preserved.
REQ-034 Random in_valid/out_ready over 1000 cycles -> output sequence equals input sequence, no loss or duplication.
